// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one branch comparator between NREQ requesters.
// Requests transfer on valid&ready; the single-stage result returns one cycle later.
module cmp_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ-1:0][2:0]  req_cmpop_i,
    input  logic [NREQ-1:0][31:0] req_a_i,
    input  logic [NREQ-1:0][31:0] req_b_i,
    output logic [NREQ-1:0]       rsp_valid_o,
    output logic                  rsp_taken_o,
    output logic                  busy_o
);

    localparam int IW = (NREQ > 2) ? 2 : 1;
    typedef logic [IW-1:0] idx_t;

    idx_t             prio_q, prio_d;
    logic             stg_valid_q, stg_valid_d;
    idx_t             stg_id_q, stg_id_d;
    logic [2:0]       stg_op_q, stg_op_d;
    logic [31:0]      stg_a_q, stg_a_d;
    logic [31:0]      stg_b_q, stg_b_d;

    logic [NREQ-1:0]  grant_s;
    idx_t             gid_s;
    logic             found_s;
    int               best_s;
    int               dist_s;

    // Branch comparator; undefined funct3 encodings never report taken.
    function automatic logic cmp_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic r;
        case (op)
            3'b000:  r = (a == b);
            3'b001:  r = (a != b);
            3'b100:  r = ($signed(a) <  $signed(b));
            3'b101:  r = ($signed(a) >= $signed(b));
            3'b110:  r = (a <  b);
            3'b111:  r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Winner is the valid port at the smallest rotational distance from prio.
    always_comb begin
        grant_s = '0;
        gid_s   = '0;
        found_s = 1'b0;
        best_s  = NREQ;
        dist_s  = 0;
        for (int j = 0; j < NREQ; j++) begin
            dist_s = (j + NREQ - int'(prio_q)) % NREQ;
            if (req_valid_i[j] && (dist_s < best_s)) begin
                best_s  = dist_s;
                gid_s   = idx_t'(j);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        if (rst || flush_i) begin
            found_s = 1'b0;
        end else begin
            found_s = found_s;
        end
        for (int j = 0; j < NREQ; j++) begin
            grant_s[j] = found_s && (gid_s == idx_t'(j));
        end
    end

    // Next-state for the priority pointer and the stage register.
    always_comb begin
        prio_d      = prio_q;
        stg_valid_d = 1'b0;
        stg_id_d    = stg_id_q;
        stg_op_d    = stg_op_q;
        stg_a_d     = stg_a_q;
        stg_b_d     = stg_b_q;
        if (found_s) begin
            prio_d      = (gid_s == idx_t'(NREQ - 1)) ? idx_t'(0) : gid_s + idx_t'(1);
            stg_valid_d = 1'b1;
            stg_id_d    = gid_s;
            stg_op_d    = req_cmpop_i[gid_s];
            stg_a_d     = req_a_i[gid_s];
            stg_b_d     = req_b_i[gid_s];
        end else begin
            prio_d      = prio_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= '0;
            stg_valid_q <= 1'b0;
            stg_id_q    <= '0;
            stg_op_q    <= 3'b000;
            stg_a_q     <= 32'h0000_0000;
            stg_b_q     <= 32'h0000_0000;
        end else begin
            prio_q      <= prio_d;
            stg_valid_q <= stg_valid_d;
            stg_id_q    <= stg_id_d;
            stg_op_q    <= stg_op_d;
            stg_a_q     <= stg_a_d;
            stg_b_q     <= stg_b_d;
        end
    end

    // Response steering; a flush or reset in the response cycle cancels it.
    always_comb begin
        rsp_valid_o = '0;
        for (int j = 0; j < NREQ; j++) begin
            rsp_valid_o[j] = stg_valid_q && !flush_i && !rst && (stg_id_q == idx_t'(j));
        end
    end

    assign req_ready_o = grant_s;
    assign rsp_taken_o = stg_valid_q & cmp_f(stg_op_q, stg_a_q, stg_b_q);
    assign busy_o      = stg_valid_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter (NREQ=2): directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_cmp_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       rv;
    logic [1:0]       ready;
    logic [1:0][2:0]  op;
    logic [1:0][31:0] a;
    logic [1:0][31:0] b;
    logic [1:0]       rsp;
    logic             taken;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pointer plus the one outstanding response.
    int m_prio = 0;
    bit m_pv   = 1'b0;
    int m_pid  = 0;
    bit m_pt   = 1'b0;

    cmp_arbiter #(.NREQ(2)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .req_valid_i(rv), .req_ready_o(ready),
        .req_cmpop_i(op), .req_a_i(a), .req_b_i(b),
        .rsp_valid_o(rsp), .rsp_taken_o(taken), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic bit ref_taken(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] xs, ys;
        xs = x ^ 32'h8000_0000;   // bias so unsigned order equals signed order
        ys = y ^ 32'h8000_0000;
        case (f)
            3'd0:    return x == y;
            3'd1:    return x != y;
            3'd4:    return xs < ys;
            3'd5:    return !(xs < ys);
            3'd6:    return x < y;
            3'd7:    return !(x < y);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] ref_grant(input logic [1:0] v, input int p);
        for (int k = 0; k < 2; k++) begin
            int idx;
            idx = (p + k) % 2;
            if (v[idx]) return (idx == 0) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    // Advance one clock, updating the model from the inputs seen before the edge.
    task automatic tick();
        int np; bit npv; int nid; bit nt;
        logic [1:0] g;
        np = m_prio; npv = 1'b0; nid = m_pid; nt = m_pt;
        if (rst) begin
            np = 0; nid = 0; nt = 1'b0;
        end else begin
            g = flush ? 2'b00 : ref_grant(rv, m_prio);
            if (g != 2'b00) begin
                nid = g[1] ? 1 : 0;
                npv = 1'b1;
                nt  = ref_taken(op[nid], a[nid], b[nid]);
                np  = (nid + 1) % 2;
            end
        end
        @(posedge clk);
        m_prio = np; m_pv = npv; m_pid = nid; m_pt = nt;
        #1;
    endtask

    task automatic idle();
        rv = 2'b00; flush = 1'b0; rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; rv = 2'b11;
        op = '0; a = '0; b = '0;
        tick();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready got=%b exp=00", ready); end
            n_cmp++; if (rsp !== 2'b00) begin n_bad++; $display("FAIL reset_rsp got=%b exp=00", rsp); end
            n_cmp++; if (busy !== 1'b0 || taken !== 1'b0) begin n_bad++; $display("FAIL reset_busy_taken got=%b%b exp=00", busy, taken); end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 2'b01) begin n_bad++; $display("FAIL reset_first_grant got=%b exp=01", ready); end
        tick();
        idle();
    endtask

    task automatic test_signed_unsigned();
        rv = 2'b10; op[1] = 3'd4; a[1] = 32'hFFFF_FFFF; b[1] = 32'h0000_0001;
        @(negedge clk);
        n_cmp++; if (ready !== 2'b10) begin n_bad++; $display("FAIL blt_ready got=%b exp=10", ready); end
        tick();
        op[1] = 3'd6;
        @(negedge clk);
        n_cmp++; if (rsp !== 2'b10 || taken !== 1'b1) begin n_bad++; $display("FAIL blt_rsp got=%b/%b exp=10/1", rsp, taken); end
        n_cmp++; if (ready !== 2'b10) begin n_bad++; $display("FAIL bltu_ready got=%b exp=10", ready); end
        tick();
        op[1] = 3'd5; a[1] = 32'h8000_0000; b[1] = 32'h8000_0000;
        @(negedge clk);
        n_cmp++; if (rsp !== 2'b10 || taken !== 1'b0) begin n_bad++; $display("FAIL bltu_rsp got=%b/%b exp=10/0", rsp, taken); end
        tick();
        rv = 2'b00;
        @(negedge clk);
        n_cmp++; if (rsp !== 2'b10 || taken !== 1'b1) begin n_bad++; $display("FAIL bge_rsp got=%b/%b exp=10/1", rsp, taken); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] prev;
        logic [1:0] expg;
        prev = 2'b00;
        rv = 2'b11; op[0] = 3'd0; op[1] = 3'd1;
        for (int c = 0; c < 6; c++) begin
            a[0] = $urandom; b[0] = a[0]; a[1] = $urandom; b[1] = $urandom;
            expg = (c % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_cmp++; if (ready !== expg) begin n_bad++; $display("FAIL rr_grant%0d got=%b exp=%b", c, ready, expg); end
            n_cmp++; if (rsp !== prev) begin n_bad++; $display("FAIL rr_rsp%0d got=%b exp=%b", c, rsp, prev); end
            prev = expg;
            tick();
        end
        rv = 2'b00;
        @(negedge clk);
        n_cmp++; if (rsp !== 2'b10) begin n_bad++; $display("FAIL rr_last_rsp got=%b exp=10", rsp); end
        tick();
    endtask

    task automatic test_flush();
        rv = 2'b01; op[0] = 3'd0; a[0] = 32'd7; b[0] = 32'd7;
        @(negedge clk);
        n_cmp++; if (ready !== 2'b01) begin n_bad++; $display("FAIL flush_pre_grant got=%b exp=01", ready); end
        tick();
        flush = 1'b1; rv = 2'b10; op[1] = 3'd6; a[1] = 32'd1; b[1] = 32'd2;
        @(negedge clk);
        n_cmp++; if (rsp !== 2'b00) begin n_bad++; $display("FAIL flush_rsp got=%b exp=00", rsp); end
        n_cmp++; if (ready !== 2'b00) begin n_bad++; $display("FAIL flush_ready got=%b exp=00", ready); end
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || rsp !== 2'b00) begin n_bad++; $display("FAIL flush_after got=%b/%b exp=0/00", busy, rsp); end
        n_cmp++; if (ready !== 2'b10) begin n_bad++; $display("FAIL flush_pending_grant got=%b exp=10", ready); end
        tick();
        rv = 2'b00;
        @(negedge clk);
        n_cmp++; if (rsp !== 2'b10 || taken !== 1'b1) begin n_bad++; $display("FAIL flush_p1_rsp got=%b/%b exp=10/1", rsp, taken); end
        tick();
    endtask

    task automatic test_stall_hold();
        rv = 2'b11; op[0] = 3'd0; a[0] = 32'd3; b[0] = 32'd4;
        op[1] = 3'd1; a[1] = 32'd5; b[1] = 32'd5;
        @(negedge clk);
        n_cmp++; if (ready !== 2'b01) begin n_bad++; $display("FAIL stall_first got=%b exp=01", ready); end
        tick();
        rv = 2'b10;
        @(negedge clk);
        n_cmp++; if (ready !== 2'b10) begin n_bad++; $display("FAIL stall_second got=%b exp=10", ready); end
        n_cmp++; if (rsp !== 2'b01 || taken !== 1'b0) begin n_bad++; $display("FAIL stall_p0_rsp got=%b/%b exp=01/0", rsp, taken); end
        tick();
        rv = 2'b00;
        @(negedge clk);
        n_cmp++; if (rsp !== 2'b10 || taken !== 1'b0) begin n_bad++; $display("FAIL stall_p1_rsp got=%b/%b exp=10/0", rsp, taken); end
        tick();
    endtask

    task automatic test_undef_op();
        for (int u = 2; u < 4; u++) begin
            rv = 2'b01; op[0] = 3'(u); a[0] = 32'd1; b[0] = 32'd2;
            @(negedge clk);
            n_cmp++; if (ready !== 2'b01) begin n_bad++; $display("FAIL undef%0d_ready got=%b exp=01", u, ready); end
            tick();
            rv = 2'b00;
            @(negedge clk);
            n_cmp++; if (rsp !== 2'b01 || taken !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL undef%0d_rsp got=%b/%b/%b exp=01/0/1", u, rsp, taken, busy); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [1:0] e_ready;
        logic [1:0] e_rsp;
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 7) == 0);
            rv    = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                op[p] = 3'($urandom_range(0, 7));
                a[p]  = $urandom;
                case ($urandom_range(0, 3))
                    0:       b[p] = a[p];
                    1:       b[p] = a[p] ^ 32'h8000_0000;
                    default: b[p] = $urandom;
                endcase
            end
            e_ready = (rst || flush) ? 2'b00 : ref_grant(rv, m_prio);
            e_rsp   = (m_pv && !flush && !rst) ? ((m_pid == 0) ? 2'b01 : 2'b10) : 2'b00;
            @(negedge clk);
            n_cmp++; if (ready !== e_ready) begin n_bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, ready, e_ready); end
            n_cmp++; if (rsp !== e_rsp) begin n_bad++; $display("FAIL rnd_rsp c=%0d got=%b exp=%b", c, rsp, e_rsp); end
            n_cmp++; if (taken !== (m_pv & m_pt)) begin n_bad++; $display("FAIL rnd_taken c=%0d got=%b exp=%b", c, taken, m_pv & m_pt); end
            n_cmp++; if (busy !== m_pv) begin n_bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_pv); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_signed_unsigned();
        test_round_robin();
        test_flush();
        test_stall_hold();
        test_undef_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
